// File: rtl/cutting_step_commander.sv
// Command-side controller for the cutting step driver: accepts move commands,
// divides the system clock into motor_clk and gates motor_en so exactly the commanded steps occur.
module cutting_step_commander #(
   parameter int STEP_W   = 16,
   parameter int DIV_W    = 20,
   parameter int DEF_HALF = 250000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0]  cmd_half,
   input  logic              abort,
   output logic              motor_clk,
   output logic              motor_en,
   output logic              motor_dir,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [STEP_W-1:0] steps_done
);

   localparam logic [DIV_W-1:0] DEF_HALF_W = DIV_W'(DEF_HALF);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_STOP,
      ST_FIN
   } state_t;

   state_t state;
   state_t state_nx;

   logic [DIV_W-1:0]  half_q;
   logic [DIV_W-1:0]  div_cnt;
   logic [STEP_W-1:0] steps_q;

   logic accept;
   logic zero_move;
   logic tick;
   logic rise;
   logic last_step;

   assign accept    = cmd_valid && (state == ST_IDLE);
   assign zero_move = (cmd_steps == '0);
   assign tick      = (state != ST_IDLE) && (div_cnt == (half_q - DIV_W'(1)));
   assign rise      = tick && !motor_clk;
   // The step that makes the count whole wins over a simultaneous abort.
   assign last_step = (state == ST_RUN) && rise && motor_en &&
                      ((steps_done + STEP_W'(1)) == steps_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (accept && !zero_move) begin
               state_nx = ST_ARM;
            end
         end
         ST_ARM: begin
            if (abort) begin
               state_nx = ST_STOP;
            end else if (tick) begin
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_step || abort) begin
               state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               state_nx = ST_FIN;
            end
         end
         ST_FIN: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      cmd_ready = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
   end

   // Divider phase is anchored to the accepting edge, so every tick lands on a multiple of half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if ((state == ST_IDLE) || (state == ST_FIN) || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_q    <= DEF_HALF_W;
         steps_q   <= '0;
         motor_dir <= 1'b0;
      end else if (accept) begin
         half_q  <= (cmd_half == '0) ? DEF_HALF_W : cmd_half;
         steps_q <= cmd_steps;
         if (!zero_move) begin
            motor_dir <= cmd_dir;
         end
      end
   end

   // In STOP a pending rise is suppressed, so the driver never sees an uncounted step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         motor_clk <= 1'b0;
         motor_en  <= 1'b0;
      end else begin
         unique case (state)
            ST_ARM: begin
               motor_clk <= 1'b0;
               if (tick && !abort) begin
                  motor_en <= 1'b1;
               end
            end
            ST_RUN: begin
               if (tick) begin
                  motor_clk <= !motor_clk;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  motor_clk <= 1'b0;
                  motor_en  <= 1'b0;
               end
            end
            default: begin
               motor_clk <= 1'b0;
               motor_en  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         steps_done <= '0;
         aborted    <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= (state == ST_FIN) || (accept && zero_move);
         if (accept) begin
            steps_done <= '0;
            aborted    <= 1'b0;
         end else begin
            if ((state == ST_RUN) && rise && motor_en && (steps_done != steps_q)) begin
               steps_done <= steps_done + STEP_W'(1);
            end
            if (((state == ST_ARM) || (state == ST_RUN)) && abort && !last_step) begin
               aborted <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cutting_step_commander.sv
// Bench for cutting_step_commander: a timeline model of each move is compared
// with the DUT every cycle, plus hand-computed checks on directed moves.
module tb_cutting_step_commander;

   localparam int STEP_W = 16;
   localparam int DIV_W  = 20;
   localparam int DEF_H  = 5;

   logic              clk;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_dir;
   logic [STEP_W-1:0] cmd_steps;
   logic [DIV_W-1:0]  cmd_half;
   logic              abort;
   logic              motor_clk;
   logic              motor_en;
   logic              motor_dir;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [STEP_W-1:0] steps_done;

   cutting_step_commander #(
      .STEP_W(STEP_W),
      .DIV_W(DIV_W),
      .DEF_HALF(DEF_H)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir),
      .cmd_steps(cmd_steps),
      .cmd_half(cmd_half),
      .abort(abort),
      .motor_clk(motor_clk),
      .motor_en(motor_en),
      .motor_dir(motor_dir),
      .busy(busy),
      .done(done),
      .aborted(aborted),
      .steps_done(steps_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Move timeline model: t counts clk edges since the accepting edge.
   bit have_move = 0;
   int mh        = 1;
   int mn        = 0;
   int mt        = 0;
   int mt_ab     = 0;
   bit mdir      = 0;

   int e_clk, e_en, e_busy, e_ready, e_done, e_ab, e_steps;

   bit prev_clk, prev_en, prev_dir, prev_busy;
   int rise_count, done_count, accept_cyc, done_cyc;
   int rise1_cyc, rise2_cyc, last_rise_cyc, en_fall_cyc;
   bit busy_seen;

   task automatic checkOne(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int tendOf();
      if (mt_ab != 0) return (mt_ab / mh + 1) * mh;
      return (2 * mn + 1) * mh;
   endfunction

   task automatic modelEdge();
      if (!rst_n) begin
         have_move = 0;
         mdir      = 0;
      end else if (cmd_valid && (!have_move || mn == 0 || mt > tendOf())) begin
         have_move = 1;
         mh        = (cmd_half == 0) ? DEF_H : int'(cmd_half);
         mn        = int'(cmd_steps);
         mt        = 0;
         mt_ab     = 0;
         if (mn != 0) mdir = cmd_dir;
      end else if (have_move) begin
         if (mn > 0 && mt_ab == 0 && abort && (mt + 1) < 2 * mn * mh) mt_ab = mt + 1;
         if (mt < 1000000) mt++;
      end
   endtask

   task automatic modelExpect();
      int tend, ct;
      bit ab;
      e_clk = 0; e_en = 0; e_busy = 0; e_ready = 1; e_done = 0; e_ab = 0; e_steps = 0;
      if (have_move && mn == 0) begin
         e_done = (mt == 0);
      end else if (have_move) begin
         ab      = (mt_ab != 0);
         tend    = tendOf();
         ct      = (ab && mt > mt_ab) ? mt_ab : mt;
         e_busy  = (mt <= tend);
         e_ready = !e_busy;
         e_done  = (mt == tend + 1);
         e_ab    = ab && (mt >= mt_ab);
         if (ct >= 2 * mh) begin
            e_steps = (ct - 2 * mh) / (2 * mh) + 1;
            if (e_steps > mn) e_steps = mn;
         end
         e_clk = (mt < tend) && (ct >= 2 * mh) && (((ct - 2 * mh) / mh) % 2 == 0);
         e_en  = (mt < tend) && (mt >= mh) && !(ab && mt_ab <= mh);
      end
   endtask

   task automatic checkOutput();
      modelExpect();
      checkOne("cmd_ready", cmd_ready, e_ready);
      checkOne("busy", busy, e_busy);
      checkOne("done", done, e_done);
      checkOne("aborted", aborted, e_ab);
      checkOne("steps_done", steps_done, e_steps);
      checkOne("motor_clk", motor_clk, e_clk);
      checkOne("motor_en", motor_en, e_en);
      checkOne("motor_dir", motor_dir, mdir);
      if (motor_en != prev_en) checkOne("en_change_clk_low", motor_clk, 0);
      if (motor_dir != prev_dir) checkOne("dir_change_not_busy", prev_busy, 0);
      if (motor_clk && !prev_clk && motor_en) begin
         rise_count++;
         if (rise_count == 1) rise1_cyc = cyc;
         if (rise_count == 2) rise2_cyc = cyc;
         last_rise_cyc = cyc;
      end
      if (!motor_en && prev_en) en_fall_cyc = cyc;
      if (done) begin
         if (done_count == 0) done_cyc = cyc;
         done_count++;
      end
      if (busy) busy_seen = 1;
      prev_clk  = motor_clk;
      prev_en   = motor_en;
      prev_dir  = motor_dir;
      prev_busy = busy;
   endtask

   task automatic applyStimulus(input bit vld, input bit dir, input int steps,
                                input int half, input bit ab);
      cmd_valid = vld;
      cmd_dir   = dir;
      cmd_steps = STEP_W'(steps);
      cmd_half  = DIV_W'(half);
      abort     = ab;
      @(posedge clk);
      cyc++;
      modelEdge();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic clearTrackers();
      rise_count = 0; done_count = 0; done_cyc = 0; rise1_cyc = 0; rise2_cyc = 0;
      last_rise_cyc = 0; en_fall_cyc = 0; busy_seen = 0;
   endtask

   task automatic runMove(input bit dir, input int steps, input int half,
                          input int abort_after, input bit probe);
      bit sent = 0;
      bit ab;
      clearTrackers();
      applyStimulus(1, dir, steps, half, 0);
      accept_cyc = cyc;
      for (int i = 0; i < 1000 && done_count == 0; i++) begin
         ab = (abort_after >= 0) && (rise_count == abort_after) && !sent;
         if (ab) sent = 1;
         applyStimulus(probe && (cyc - accept_cyc) < 8, !dir, 7, 1, ab);
      end
      if (done_count == 0) checkOne("move_timeout", 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOne({tag, "_motor_clk"}, motor_clk, 0);
      checkOne({tag, "_motor_en"}, motor_en, 0);
      checkOne({tag, "_motor_dir"}, motor_dir, 0);
      checkOne({tag, "_busy"}, busy, 0);
      checkOne({tag, "_done"}, done, 0);
      checkOne({tag, "_aborted"}, aborted, 0);
      checkOne({tag, "_steps_done"}, steps_done, 0);
      checkOne({tag, "_cmd_ready"}, cmd_ready, 1);
      prev_clk = 0; prev_en = 0; prev_dir = 0; prev_busy = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 0; cmd_dir = 0; cmd_steps = '0; cmd_half = '0; abort = 0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;

      // Basic move with a busy-time command probe that must be ignored.
      runMove(1, 4, 3, -1, 1);
      checkOne("basic_rises", rise_count, 4);
      checkOne("basic_done_pulses", done_count, 1);
      checkOne("basic_accept_to_done", done_cyc - accept_cyc, 28);
      checkOne("basic_steps_done", steps_done, 4);
      checkOne("basic_dir", motor_dir, 1);
      checkOne("basic_aborted", aborted, 0);
      checkOne("basic_ready_after", cmd_ready, 1);

      runMove(0, 0, 3, -1, 0);
      checkOne("zero_done_latency", done_cyc - accept_cyc, 0);
      checkOne("zero_rises", rise_count, 0);
      checkOne("zero_busy_seen", busy_seen, 0);
      checkOne("zero_dir_kept", motor_dir, 1);

      runMove(0, 3, 0, -1, 0);
      checkOne("default_period", rise2_cyc - rise1_cyc, 10);
      checkOne("default_rises", rise_count, 3);

      runMove(1, 100, 2, 7, 0);
      checkOne("abort_steps_done", steps_done, 7);
      checkOne("abort_aborted", aborted, 1);
      checkOne("abort_done_pulses", done_count, 1);
      checkOne("abort_en_fall_delay", en_fall_cyc - last_rise_cyc, 2);

      // Asynchronous reset in the middle of a run.
      clearTrackers();
      applyStimulus(1, 1, 10, 2, 0);
      for (int i = 0; i < 200 && rise_count < 3; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOne("pre_reset_rises", rise_count, 3);
      #2 rst_n = 1'b0;
      #1 checkResetValues("async_reset");
      have_move = 0;
      mdir = 0;
      applyStimulus(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      runMove(0, 2, 2, -1, 0);
      checkOne("post_reset_rises", rise_count, 2);
      checkOne("post_reset_steps_done", steps_done, 2);

      for (int i = 0; i < 2500; i++) begin
         applyStimulus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 5), $urandom_range(0, 3),
                       $urandom_range(0, 29) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cutting_step_commander.md
Name: cutting_step_commander

Overview:
Command-side controller for the cutting step driver.
- Accepts move commands (direction, step count, step rate) over a valid/ready handshake.
- Generates the divided motor clock.
- Drives the driver's en/direction inputs so exactly the commanded number of steps is executed.
- Reports progress and completion to the cut controller.
- Runs on the system clock; the driver is clocked by motor_clk.

Parameters:
STEP_W, 16, width of step count and progress counter
DIV_W, 20, width of half-period divider value
DEF_HALF, 250000, half-period (clk cycles) used when cmd_half is 0

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  move command offered
cmd_ready  output  1  commander can accept a command (high only in IDLE)
cmd_dir  input  1  0 = clockwise, 1 = counter-clockwise (driver encoding)
cmd_steps  input  STEP_W  number of steps to execute
cmd_half  input  DIV_W  motor_clk half-period in clk cycles; 0 selects DEF_HALF
abort  input  1  stop current move at the next safe point
motor_clk  output  1  step clock to the driver
motor_en  output  1  driver enable
motor_dir  output  1  driver direction
busy  output  1  move in progress
done  output  1  one-cycle pulse at move completion or abort
aborted  output  1  latched high if the last move ended by abort; cleared on next accept
steps_done  output  STEP_W  steps executed in the current/last move

Behaviour:
- Reset is clk, rst_n, asynchronous, active-low. Outputs on reset: motor_clk=0, motor_en=0, motor_dir=0, busy=0, done=0, aborted=0, steps_done=0, cmd_ready=1. FSM goes to IDLE and the divider counter to 0.
- Handshake: a command is accepted on a clk edge with cmd_valid && cmd_ready.
  - On accept, latch dir, steps and half. A latched half of 0 becomes DEF_HALF.
  - On accept, clear steps_done and aborted.
- Divider:
  - Counter runs 0..half-1 in every state except IDLE.
  - On reaching half-1 it wraps to 0 and toggles motor_clk.
  - motor_clk period = 2*half clk cycles.
  - In IDLE, counter=0 and motor_clk=0.
- States:
  - IDLE: cmd_ready=1, busy=0.
    - Accept with steps=0 -> done pulses next cycle; stay IDLE; no motor_clk edges.
    - Accept with steps>0 -> ARM, busy=1.
  - ARM:
    - motor_dir <= latched dir at entry.
    - motor_en is asserted on the first falling toggle point, i.e. while motor_clk is low, at the cycle motor_clk would toggle high. motor_clk stays low for that period. Move to RUN.
    - Purpose: en is stable for a full half-period before the driver samples it.
  - RUN:
    - On each clk edge where motor_clk toggles 0->1 with motor_en=1, steps_done increments.
    - When steps_done reaches steps, go to STOP.
  - STOP:
    - At the next motor_clk 1->0 toggle, motor_en <= 0.
    - On the following cycle: done=1, motor_clk forced 0, counter cleared, return to IDLE.
- motor_dir never changes while busy. After a move it holds the last value until the next accept.
- motor_en changes only on cycles where motor_clk toggles 1->0, or at the ARM entry point while motor_clk is low. It never changes while motor_clk is high.
- abort:
  - Sampled in ARM or RUN; forces STOP and sets aborted. steps_done freezes at its current value.
  - An abort in ARM before en is asserted gives done with steps_done=0.
  - abort in IDLE or STOP is ignored.
  - abort in the same cycle as the final step completes: STOP with aborted=0, since the step count completed first.
- cmd_valid while busy is ignored (cmd_ready=0). The command is not queued.
- Reset mid-move: all outputs return to reset values immediately (asynchronous). The driver sees en=0.
- steps_done saturates at steps; it never wraps.
- Latency:
  - Accept -> first motor_clk rise with en: at most 2*half+2 clk cycles.
  - Last step rise -> done: half+1 to 2*half+1 clk cycles.

Test Plan:
- Basic move: cmd_steps=4, cmd_half=3, cmd_dir=1 → motor_clk period 6 clk; exactly 4 rises with motor_en=1; motor_dir=1 throughout; steps_done=4; single done pulse; aborted=0; cmd_ready high again after done.
- Zero steps: cmd_steps=0 → done pulse 1 cycle after accept; motor_clk stays 0 and motor_en stays 0; busy never asserted.
- Default rate: cmd_half=0, DEF_HALF overridden to 5 → motor_clk period 10 clk.
- Abort mid-move: cmd_steps=100, cmd_half=2, abort after 7th counted rise → motor_en falls on next motor_clk fall; steps_done=7; aborted=1; one done pulse.
- Busy rejection and timing checks: second cmd_valid during a move → cmd_ready=0, ignored, first move completes unchanged. Assertion: motor_en and motor_dir never change while motor_clk=1.
- Async reset mid-RUN: rst_n low for 1 cycle at step 3 of 10 → all outputs reset immediately; after release, a new command of 2 steps executes exactly 2 steps.
